// File: rtl/rx_edge_bit_timer_pkg.sv
// rx_edge_bit_timer shared types and constants.
// RX_TRIPLE_SAMPLE_EN selects three strobes per bit and a higher prescale floor.
package rx_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_ERR  = 2'd3
  } timer_state_e;

`ifdef RX_TRIPLE_SAMPLE_EN
  localparam int PRESC_MIN = 4;
`else
  localparam int PRESC_MIN = 2;
`endif

  localparam logic [1:0] SMP_EARLY = 2'd0;
  localparam logic [1:0] SMP_MID   = 2'd1;
  localparam logic [1:0] SMP_LATE  = 2'd2;

endpackage

// File: rtl/rx_edge_bit_timer_if.sv
// Config/status bundle between the RX FSM and the bit timer.
// Master side configures and enables; slave side is the timer.
interface rx_edge_bit_timer_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);
  logic                  cnt_en;
  logic [PRESCALE_W-1:0] prescale;
  logic [BIT_CNT_W-1:0]  frame_bits;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sample_stb;
  logic [1:0]            sample_idx;
  logic                  bit_end;
  logic                  frame_done;
  logic                  presc_err;

  modport master (
    output cnt_en, prescale, frame_bits,
    input  edge_cnt, bit_cnt, sample_stb,
    input  sample_idx, bit_end, frame_done,
    input  presc_err
  );

  modport slave (
    input  cnt_en, prescale, frame_bits,
    output edge_cnt, bit_cnt, sample_stb,
    output sample_idx, bit_end, frame_done,
    output presc_err
  );
endinterface

// File: rtl/rx_edge_bit_timer_decode.sv
// Mid-bit sample strobe decode from the registered edge counter.
// RX_TRIPLE_SAMPLE_EN adds the mid-1/mid+1 strobes for majority voting.
module rx_sample_decode
  import rx_timer_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic [PRESCALE_W-1:0] i_edge_cnt,
  input  logic [PRESCALE_W-1:0] i_prescale_q,
  input  logic                  i_run,
  output logic                  o_sample_stb,
  output logic [1:0]            o_sample_idx
);

  logic [PRESCALE_W-1:0] w_mid;

  assign w_mid = i_prescale_q >> 1;

`ifdef RX_TRIPLE_SAMPLE_EN
  logic [PRESCALE_W-1:0] w_early;
  logic [PRESCALE_W-1:0] w_late;

  assign w_early = w_mid - PRESCALE_W'(1);
  assign w_late  = w_mid + PRESCALE_W'(1);

  // three strobes around the bit centre
  always_comb begin
    o_sample_stb = 1'b0;
    o_sample_idx = SMP_EARLY;
    unique case (1'b1)
      (i_run && i_edge_cnt == w_early): begin
        o_sample_stb = 1'b1;
        o_sample_idx = SMP_EARLY;
      end
      (i_run && i_edge_cnt == w_mid): begin
        o_sample_stb = 1'b1;
        o_sample_idx = SMP_MID;
      end
      (i_run && i_edge_cnt == w_late): begin
        o_sample_stb = 1'b1;
        o_sample_idx = SMP_LATE;
      end
      default: ;
    endcase
  end
`else
  // single strobe at the bit centre
  always_comb begin
    o_sample_stb = 1'b0;
    o_sample_idx = 2'd0;
    if (i_run && i_edge_cnt == w_mid) begin
      o_sample_stb = 1'b1;
      o_sample_idx = SMP_MID;
    end
  end
`endif

endmodule

// File: rtl/rx_edge_bit_timer.sv
// UART RX oversampling edge/bit timer with per-frame config latch.
// Sample strobe width set by RX_TRIPLE_SAMPLE_EN (in decode and package).
module rx_edge_bit_timer
  import rx_timer_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  rx_edge_bit_timer_if.slave bus
);

  timer_state_e          r_state;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [PRESCALE_W-1:0] r_presc_q;
  logic [BIT_CNT_W-1:0]  r_fbits_q;

  timer_state_e          w_state_nx;
  logic [PRESCALE_W-1:0] w_edge_nx;
  logic [BIT_CNT_W-1:0]  w_bit_nx;
  logic [PRESCALE_W-1:0] w_presc_nx;
  logic [BIT_CNT_W-1:0]  w_fbits_nx;

  logic [PRESCALE_W-1:0] w_presc_eff;
  logic [BIT_CNT_W-1:0]  w_fbits_eff;
  logic [PRESCALE_W-1:0] w_presc_m1;
  logic [BIT_CNT_W-1:0]  w_fbits_m1;
  logic                  w_cfg_ok;
  logic                  w_run;
  logic                  w_last_edge;
  logic                  w_bit_end;
  logic                  w_frame_done;
  logic                  w_stb;
  logic [1:0]            w_idx;

  // live config while idle, latched config once a frame has started
  assign w_presc_eff = (r_state == ST_IDLE) ? bus.prescale
                                            : r_presc_q;
  assign w_fbits_eff = (r_state == ST_IDLE) ? bus.frame_bits
                                            : r_fbits_q;
  assign w_presc_m1  = w_presc_eff - PRESCALE_W'(1);
  assign w_fbits_m1  = w_fbits_eff - BIT_CNT_W'(1);

  assign w_cfg_ok = (bus.prescale >= PRESCALE_W'(PRESC_MIN))
                 && (bus.frame_bits != '0);

  assign w_run        = (r_state == ST_RUN);
  assign w_last_edge  = (r_edge_cnt == w_presc_m1);
  assign w_bit_end    = w_run && w_last_edge;
  assign w_frame_done = w_bit_end && (r_bit_cnt == w_fbits_m1);

  // state, counters and latched config
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_presc_q  <= '0;
      r_fbits_q  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_edge_cnt <= w_edge_nx;
      r_bit_cnt  <= w_bit_nx;
      r_presc_q  <= w_presc_nx;
      r_fbits_q  <= w_fbits_nx;
    end
  end

  // next state and counter values; cnt_en low overrides everything
  always_comb begin
    w_state_nx = r_state;
    w_edge_nx  = r_edge_cnt;
    w_bit_nx   = r_bit_cnt;
    w_presc_nx = r_presc_q;
    w_fbits_nx = r_fbits_q;
    unique case (r_state)
      ST_IDLE: begin
        w_edge_nx = '0;
        w_bit_nx  = '0;
        if (bus.cnt_en) begin
          if (w_cfg_ok) begin
            w_presc_nx = bus.prescale;
            w_fbits_nx = bus.frame_bits;
            w_edge_nx  = PRESCALE_W'(1);
            w_state_nx = ST_RUN;
          end else begin
            w_state_nx = ST_ERR;
          end
        end
      end
      ST_RUN: begin
        if (w_last_edge) begin
          w_edge_nx = '0;
          if (w_frame_done) begin
            w_bit_nx   = '0;
            w_state_nx = ST_HOLD;
          end else begin
            w_bit_nx = r_bit_cnt + BIT_CNT_W'(1);
          end
        end else begin
          w_edge_nx = r_edge_cnt + PRESCALE_W'(1);
        end
      end
      ST_HOLD: begin
        w_edge_nx = '0;
        w_bit_nx  = '0;
      end
      ST_ERR: begin
        w_edge_nx = '0;
        w_bit_nx  = '0;
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_edge_nx  = '0;
        w_bit_nx   = '0;
      end
    endcase
    if (!bus.cnt_en) begin
      w_state_nx = ST_IDLE;
      w_edge_nx  = '0;
      w_bit_nx   = '0;
    end
  end

  rx_sample_decode #(
    .PRESCALE_W (PRESCALE_W)
  ) u_decode (
    .i_edge_cnt   (r_edge_cnt),
    .i_prescale_q (r_presc_q),
    .i_run        (w_run),
    .o_sample_stb (w_stb),
    .o_sample_idx (w_idx)
  );

  assign bus.edge_cnt   = r_edge_cnt;
  assign bus.bit_cnt    = r_bit_cnt;
  assign bus.bit_end    = w_bit_end;
  assign bus.frame_done = w_frame_done;
  assign bus.sample_stb = w_stb;
  assign bus.sample_idx = w_idx;
  assign bus.presc_err  = (r_state == ST_ERR);

endmodule

// File: tb/tb_rx_edge_bit_timer.sv
// Directed bench for rx_edge_bit_timer.
// Expectations follow RX_TRIPLE_SAMPLE_EN when it is defined.
module tb_rx_edge_bit_timer;

  localparam int PW = 6;
  localparam int BW = 4;

`ifdef RX_TRIPLE_SAMPLE_EN
  localparam int BAD_PQ = 3;
`else
  localparam int BAD_PQ = 1;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rx_edge_bit_timer_if #(
    .PRESCALE_W (PW),
    .BIT_CNT_W  (BW)
  ) bus ();

  rx_edge_bit_timer #(
    .PRESCALE_W (PW),
    .BIT_CNT_W  (BW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_pass = 0;
  int n_tot  = 0;

  function automatic logic [15:0] obs();
    return {bus.edge_cnt, bus.bit_cnt, bus.bit_end,
            bus.frame_done, bus.sample_stb,
            bus.sample_idx, bus.presc_err};
  endfunction

  function automatic logic [15:0] mk(
    int e, int b, logic be, logic fd,
    logic stb, logic [1:0] idx, logic err);
    return {6'(e), 4'(b), be, fd, stb, idx, err};
  endfunction

  // expected {stb, idx} for edge e at prescale pq
  function automatic logic [2:0] exp_smp(
    int e, int pq, logic run);
    int mid;
    mid = pq / 2;
    if (!run) return 3'b000;
`ifdef RX_TRIPLE_SAMPLE_EN
    if (e == mid - 1) return 3'b100;
    if (e == mid)     return 3'b101;
    if (e == mid + 1) return 3'b110;
`else
    if (e == mid) return 3'b101;
`endif
    return 3'b000;
  endfunction

  // Full frame from IDLE with cnt_en held; optional mid-frame
  // prescale change (chg_at) and abort (stop_at). Entered and
  // left at a negedge with cnt_en low.
  task automatic run_frame(input string nm, input int pq,
                           input int fb, input int chg_at,
                           input int chg_pq, input int stop_at);
    logic [15:0] want;
    logic [2:0]  s;
    int e, b;
    logic be, fd;
    bus.prescale   = 6'(pq);
    bus.frame_bits = 4'(fb);
    bus.cnt_en     = 1'b1;
    for (int c = 1; c <= pq * fb; c++) begin
      e  = (c - 1) % pq;
      b  = (c - 1) / pq;
      be = (e == pq - 1);
      fd = be && (b == fb - 1);
      s  = exp_smp(e, pq, c > 1);
      want = mk(e, b, be, fd, s[2], s[1:0], 1'b0);
      n_tot++;
      if (obs() !== want)
        $display("FAIL %s cyc=%0d got=%h want=%h",
                 nm, c, obs(), want);
      else n_pass++;
      if (c == chg_at) bus.prescale = 6'(chg_pq);
      if (c == stop_at) begin
        bus.cnt_en = 1'b0;
        @(negedge clk);
        n_tot++;
        if (obs() !== 16'h0)
          $display("FAIL %s_abort got=%h want=0000",
                   nm, obs());
        else n_pass++;
        return;
      end
      @(negedge clk);
    end
    for (int h = 0; h < 3; h++) begin
      n_tot++;
      if (obs() !== 16'h0)
        $display("FAIL %s_hold%0d got=%h want=0000",
                 nm, h, obs());
      else n_pass++;
      @(negedge clk);
    end
    bus.cnt_en = 1'b0;
    @(negedge clk);
    n_tot++;
    if (obs() !== 16'h0)
      $display("FAIL %s_idle got=%h want=0000", nm, obs());
    else n_pass++;
  endtask

  task automatic test_reset();
    bus.cnt_en     = 1'b0;
    bus.prescale   = 6'd8;
    bus.frame_bits = 4'd10;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    n_tot++;
    if (obs() !== 16'h0)
      $display("FAIL reset_async got=%h want=0000", obs());
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tot++;
    if (obs() !== 16'h0)
      $display("FAIL reset_idle got=%h want=0000", obs());
    else n_pass++;
  endtask

  task automatic test_basic();
    run_frame("p8f10", 8, 10, 0, 0, 0);
  endtask

  task automatic test_cfg_change();
    run_frame("chg", 8, 10, 20, 16, 0);
    run_frame("p16f10", 16, 10, 0, 0, 0);
  endtask

  task automatic test_abort();
    run_frame("abort", 8, 10, 0, 0, 38);
    // re-enable straight from IDLE: edge 0 then 1
    bus.cnt_en = 1'b1;
    n_tot++;
    if (bus.edge_cnt !== 6'd0)
      $display("FAIL abort_re0 got=%0d want=0",
               bus.edge_cnt);
    else n_pass++;
    @(negedge clk);
    n_tot++;
    if (bus.edge_cnt !== 6'd1)
      $display("FAIL abort_re1 got=%0d want=1",
               bus.edge_cnt);
    else n_pass++;
    bus.cnt_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_err();
    logic [15:0] err_w;
    err_w = mk(0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    // zero frame length
    bus.prescale   = 6'd8;
    bus.frame_bits = 4'd0;
    bus.cnt_en     = 1'b1;
    @(negedge clk);
    bus.frame_bits = 4'd10;
    for (int k = 0; k < 3; k++) begin
      n_tot++;
      if (obs() !== err_w)
        $display("FAIL err_fb0_%0d got=%h want=%h",
                 k, obs(), err_w);
      else n_pass++;
      @(negedge clk);
    end
    bus.cnt_en = 1'b0;
    @(negedge clk);
    n_tot++;
    if (obs() !== 16'h0)
      $display("FAIL err_fb0_clr got=%h want=0000", obs());
    else n_pass++;
    // prescale one below the floor
    bus.prescale = 6'(BAD_PQ);
    bus.cnt_en   = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_tot++;
      if (obs() !== err_w)
        $display("FAIL err_pq_%0d got=%h want=%h",
                 k, obs(), err_w);
      else n_pass++;
      @(negedge clk);
    end
    bus.cnt_en = 1'b0;
    @(negedge clk);
    n_tot++;
    if (obs() !== 16'h0)
      $display("FAIL err_pq_clr got=%h want=0000", obs());
    else n_pass++;
`ifndef RX_TRIPLE_SAMPLE_EN
    run_frame("p3f10", 3, 10, 0, 0, 0);
`endif
  endtask

  task automatic test_long();
    run_frame("p32f11", 32, 11, 0, 0, 0);
    run_frame("p9f4", 9, 4, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    logic [15:0] want;
    bus.prescale   = 6'd8;
    bus.frame_bits = 4'd10;
    bus.cnt_en     = 1'b1;
    repeat (13) @(negedge clk);
    // cycle 14: edge 5 of bit 1, late strobe in triple mode
    want = mk(5, 1, 1'b0, 1'b0,
              exp_smp(5, 8, 1'b1) >> 2,
              exp_smp(5, 8, 1'b1) & 3'b011, 1'b0);
    n_tot++;
    if (obs() !== want)
      $display("FAIL arst_pre got=%h want=%h", obs(), want);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_tot++;
    if (obs() !== 16'h0)
      $display("FAIL arst_now got=%h want=0000", obs());
    else n_pass++;
    @(negedge clk);
    bus.cnt_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    run_frame("arst_p9", 9, 2, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cfg_change();
    test_abort();
    test_err();
    test_long();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
